// File: rtl/read_buffer_pkg.sv
// -----------------------------------------------------------------------------
// read_buffer_pkg
//   Shared constants for the line-unpacking stage that sits between the AXI
//   read-data channel and the element FIFOs of the PageRank engine.
//
//   LINE_W   : default memory line width in bits
//   WORD_W   : default element width in bits
//   IDX_W    : width of the element index (base / bounds / pointer)
//   ELEMS()  : number of elements of a given width in a LINE_W line
// -----------------------------------------------------------------------------
package read_buffer_pkg;

    localparam int LINE_W = 512;
    localparam int WORD_W = 64;
    localparam int IDX_W  = 8;

    function automatic int ELEMS(input int width);
        return LINE_W / width;
    endfunction

endpackage : read_buffer_pkg

// File: rtl/read_buffer.sv
// -----------------------------------------------------------------------------
// read_buffer
//   Captures one FULL_WIDTH-bit memory line when the read-data qualifier fires
//   and then emits the elements [base, min(bounds, N)) one per cycle, MSB-first,
//   whenever the downstream FIFO can accept data.
//
// Parameters
//   FULL_WIDTH : line width in bits
//   WIDTH      : element width in bits; N = FULL_WIDTH/WIDTH must be 1..255
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   rready     in   line-capture strobe (rvalid & matching rid)
//   rdata      in   line data, sampled when rready=1
//   odata_req  in   downstream can accept an element
//   base       in   first element index to emit, sampled with rdata
//   bounds     in   exclusive end index, sampled with rdata
//   oready     out  one-cycle valid for odata
//   odata      out  element data (holds its last value while oready=0)
// -----------------------------------------------------------------------------
module read_buffer
    import read_buffer_pkg::*;
#(
    parameter int FULL_WIDTH = LINE_W,
    parameter int WIDTH      = WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rready,
    input  logic [FULL_WIDTH-1:0] rdata,
    input  logic                  odata_req,
    input  logic [IDX_W-1:0]      base,
    input  logic [IDX_W-1:0]      bounds,
    output logic                  oready,
    output logic [WIDTH-1:0]      odata
);

    localparam int               N     = FULL_WIDTH / WIDTH;
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N);

    logic [FULL_WIDTH-1:0] r_line;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_end;
    logic                  r_oready;
    logic [WIDTH-1:0]      r_odata;

    logic [WIDTH-1:0]      w_elems [N];
    logic [WIDTH-1:0]      w_sel;
    logic [IDX_W-1:0]      w_end_clamped;
    logic                  w_draining;
    logic                  w_emit;

    // Element 0 lives in the top bits of the line.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign w_elems[gi] = r_line[FULL_WIDTH-1-WIDTH*gi -: WIDTH];
        end
    endgenerate

    // Pointer-driven element mux. Pointer values >= N only occur when the
    // block is idle, where the selected value is never used.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ptr == IDX_W'(i)) begin
                w_sel = w_elems[i];
            end
        end
    end

    // Requests past the end of the line are clamped to the line length.
    assign w_end_clamped = (bounds < N_IDX) ? bounds : N_IDX;

    assign w_draining = (r_ptr < r_end);

    // A capture on the same edge takes priority over emission.
    assign w_emit = !rready && w_draining && odata_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line   <= '0;
            r_ptr    <= '0;
            r_end    <= '0;
            r_oready <= 1'b0;
            r_odata  <= '0;
        end else if (rready) begin
            // New line replaces whatever was left of the previous one.
            r_line   <= rdata;
            r_ptr    <= base;
            r_end    <= w_end_clamped;
            r_oready <= 1'b0;
        end else if (w_emit) begin
            r_oready <= 1'b1;
            r_odata  <= w_sel;
            r_ptr    <= r_ptr + 1'b1;
        end else begin
            r_oready <= 1'b0;
        end
    end

    assign oready = r_oready;
    assign odata  = r_odata;

endmodule : read_buffer

// File: tb/tb_read_buffer.sv
module tb_read_buffer;

    logic         clk;
    logic         rst;
    logic         rready;
    logic [511:0] rdata;
    logic         odata_req;
    logic [7:0]   base;
    logic [7:0]   bounds;

    logic         oready64;
    logic [63:0]  odata64;
    logic         oready128;
    logic [127:0] odata128;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of elements still owed per instance.
    logic [63:0]  q64  [$];
    logic [127:0] q128 [$];
    logic         e_rdy64;
    logic [63:0]  e_d64;
    logic         e_rdy128;
    logic [127:0] e_d128;

    read_buffer #(.FULL_WIDTH(512), .WIDTH(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .rready    (rready),
        .rdata     (rdata),
        .odata_req (odata_req),
        .base      (base),
        .bounds    (bounds),
        .oready    (oready64),
        .odata     (odata64)
    );

    read_buffer #(.FULL_WIDTH(512), .WIDTH(128)) u_dut128 (
        .clk       (clk),
        .rst       (rst),
        .rready    (rready),
        .rdata     (rdata),
        .odata_req (odata_req),
        .base      (base),
        .bounds    (bounds),
        .oready    (oready128),
        .odata     (odata128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_capture();
        int e;
        e = (int'(bounds) < 8) ? int'(bounds) : 8;
        q64.delete();
        for (int i = int'(base); i < e; i++)
            q64.push_back(64'(rdata >> (512 - 64 * (i + 1))));
        e = (int'(bounds) < 4) ? int'(bounds) : 4;
        q128.delete();
        for (int i = int'(base); i < e; i++)
            q128.push_back(128'(rdata >> (512 - 128 * (i + 1))));
    endtask

    task automatic model_clear();
        q64.delete();
        q128.delete();
        e_rdy64  = 1'b0;
        e_d64    = '0;
        e_rdy128 = 1'b0;
        e_d128   = '0;
    endtask

    // Advance one clock edge, updating the model from the inputs seen at it.
    task automatic tick();
        if (!rst) begin
            if (rready) begin
                model_capture();
                e_rdy64  = 1'b0;
                e_rdy128 = 1'b0;
            end else begin
                if (odata_req && q64.size() > 0) begin
                    e_rdy64 = 1'b1;
                    e_d64   = q64.pop_front();
                end else begin
                    e_rdy64 = 1'b0;
                end
                if (odata_req && q128.size() > 0) begin
                    e_rdy128 = 1'b1;
                    e_d128   = q128.pop_front();
                end else begin
                    e_rdy128 = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_capture(input logic [511:0] line, input logic [7:0] b, input logic [7:0] bd);
        rready = 1'b1;
        rdata  = line;
        base   = b;
        bounds = bd;
        tick();
        rready = 1'b0;
    endtask

    function automatic logic [511:0] seq_line();
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[511 - 64 * i -: 64] = 64'h10 + 64'(i);
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rready = 1'b0; rdata = '0; odata_req = 1'b0; base = '0; bounds = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oready64 !== 1'b0) begin errors++; $display("FAIL reset_oready64: got %0b want 0", oready64); end
        checks++; if (odata64 !== 64'h0) begin errors++; $display("FAIL reset_odata64: got %h want 0", odata64); end
        checks++; if (oready128 !== 1'b0) begin errors++; $display("FAIL reset_oready128: got %0b want 0", oready128); end
        checks++; if (odata128 !== 128'h0) begin errors++; $display("FAIL reset_odata128: got %h want 0", odata128); end
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    // Full 128-bit line drained with odata_req held high.
    task automatic test_w128_full();
        logic [511:0] line;
        int p128 = 0;
        for (int i = 0; i < 16; i++) line[511 - 32 * i -: 32] = $urandom();
        odata_req = 1'b1;
        do_capture(line, 8'd0, 8'd4);
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL w128_full w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL w128_full w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready128, odata128, e_rdy128, e_d128);
            end
            if (k < 4) begin
                checks++;
                if (oready128 !== 1'b1 || odata128 !== line[511 - 128 * k -: 128]) begin
                    errors++; $display("FAIL w128_order elem%0d: got oready=%0b odata=%h want 1 %h", k, oready128, odata128, line[511 - 128 * k -: 128]);
                end
            end
            if (oready128) p128++;
        end
        checks++; if (p128 != 4) begin errors++; $display("FAIL w128_pulses: got %0d want 4", p128); end
        $display("test_w128_full: pulses128=%0d", p128);
    endtask

    // Capture with a given window; compare against model and fixed pulse counts.
    task automatic test_window(input logic [7:0] b, input logic [7:0] bd, input int want64, input int want128);
        int p64 = 0;
        int p128 = 0;
        odata_req = 1'b1;
        do_capture(seq_line(), b, bd);
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL window b%0d bd%0d w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", b, bd, k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL window b%0d bd%0d w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", b, bd, k, oready128, odata128, e_rdy128, e_d128);
            end
            if (oready64) begin
                checks++;
                if (odata64 !== 64'h10 + 64'(b) + 64'(p64)) begin
                    errors++; $display("FAIL window_value64 b%0d: got %h want %h", b, odata64, 64'h10 + 64'(b) + 64'(p64));
                end
                p64++;
            end
            if (oready128) p128++;
        end
        checks++; if (p64 != want64) begin errors++; $display("FAIL window_pulses64 b%0d bd%0d: got %0d want %0d", b, bd, p64, want64); end
        checks++; if (p128 != want128) begin errors++; $display("FAIL window_pulses128 b%0d bd%0d: got %0d want %0d", b, bd, p128, want128); end
        $display("test_window base=%0d bounds=%0d: pulses64=%0d pulses128=%0d", b, bd, p64, p128);
    endtask

    // odata_req dropped for 3 cycles after the 2nd element.
    task automatic test_stall();
        int p64 = 0;
        odata_req = 1'b1;
        do_capture(seq_line(), 8'd0, 8'd8);
        for (int k = 0; k < 14; k++) begin
            odata_req = (k < 2 || k >= 5);
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL stall w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL stall w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready128, odata128, e_rdy128, e_d128);
            end
            if (k >= 2 && k < 5) begin
                checks++;
                if (oready64 !== 1'b0) begin errors++; $display("FAIL stall_quiet cyc%0d: got oready=%0b want 0", k, oready64); end
            end
            if (k == 5) begin
                checks++;
                if (oready64 !== 1'b1 || odata64 !== 64'h12) begin
                    errors++; $display("FAIL stall_resume: got oready=%0b odata=%h want 1 0000000000000012", oready64, odata64);
                end
            end
            if (oready64) begin
                checks++;
                if (odata64 !== 64'h10 + 64'(p64)) begin
                    errors++; $display("FAIL stall_seq: got %h want %h", odata64, 64'h10 + 64'(p64));
                end
                p64++;
            end
        end
        checks++; if (p64 != 8) begin errors++; $display("FAIL stall_pulses: got %0d want 8", p64); end
        $display("test_stall: pulses64=%0d", p64);
    endtask

    // New capture while the previous line is still draining.
    task automatic test_capture_wins();
        logic [511:0] line;
        odata_req = 1'b1;
        do_capture(seq_line(), 8'd0, 8'd8);
        repeat (2) tick();
        for (int i = 0; i < 16; i++) line[511 - 32 * i -: 32] = $urandom();
        do_capture(line, 8'd1, 8'd3);
        checks++;
        if (oready64 !== 1'b0) begin errors++; $display("FAIL capture_wins_edge: got oready=%0b want 0", oready64); end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL capture_wins w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL capture_wins w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready128, odata128, e_rdy128, e_d128);
            end
        end
        $display("test_capture_wins: done");
    endtask

    // Asynchronous reset after 2 of 8 elements.
    task automatic test_reset_mid_drain();
        int p64 = 0;
        odata_req = 1'b1;
        do_capture(seq_line(), 8'd0, 8'd8);
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (oready64 !== 1'b0) begin errors++; $display("FAIL mid_reset_oready64: got %0b want 0", oready64); end
        checks++; if (odata64 !== 64'h0) begin errors++; $display("FAIL mid_reset_odata64: got %h want 0", odata64); end
        checks++; if (oready128 !== 1'b0) begin errors++; $display("FAIL mid_reset_oready128: got %0b want 0", oready128); end
        checks++; if (odata128 !== 128'h0) begin errors++; $display("FAIL mid_reset_odata128: got %h want 0", odata128); end
        model_clear();
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL after_reset w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL after_reset w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready128, odata128, e_rdy128, e_d128);
            end
            if (oready64) p64++;
        end
        checks++; if (p64 != 0) begin errors++; $display("FAIL after_reset_pulses: got %0d want 0", p64); end
        $display("test_reset_mid_drain: pulses after release=%0d", p64);
    endtask

    // Random lines, windows and back-pressure; captures only while idle.
    task automatic test_random();
        int caps = 0;
        logic [511:0] line;
        for (int k = 0; k < 400; k++) begin
            if (q64.size() == 0 && q128.size() == 0 && !e_rdy64 && !e_rdy128 && ($urandom_range(0, 2) == 0)) begin
                for (int i = 0; i < 16; i++) line[511 - 32 * i -: 32] = $urandom();
                rready = 1'b1;
                rdata  = line;
                base   = 8'($urandom_range(0, 9));
                bounds = 8'($urandom_range(0, 12));
                caps++;
            end else begin
                rready = 1'b0;
                rdata  = {16{$urandom()}};
                base   = 8'($urandom());
                bounds = 8'($urandom());
            end
            odata_req = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if ({oready64, odata64} !== {e_rdy64, e_d64}) begin
                errors++; $display("FAIL random w64 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready64, odata64, e_rdy64, e_d64);
            end
            checks++;
            if ({oready128, odata128} !== {e_rdy128, e_d128}) begin
                errors++; $display("FAIL random w128 cyc%0d: got oready=%0b odata=%h want oready=%0b odata=%h", k, oready128, odata128, e_rdy128, e_d128);
            end
        end
        rready = 1'b0;
        $display("test_random: captures=%0d", caps);
    endtask

    initial begin
        test_reset();
        test_w128_full();
        test_window(8'd3, 8'd8, 5, 1);
        test_window(8'd0, 8'd2, 2, 2);
        test_window(8'd0, 8'd12, 8, 4);
        test_window(8'd5, 8'd5, 0, 0);
        test_window(8'd0, 8'd1, 1, 1);
        test_stall();
        test_capture_wins();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_read_buffer
